// File: rtl/an_sec_correct_ctrl.sv
// an_sec_correct_ctrl: serial AN-code single-error correction controller.
// Accepts a codeword, reduces it mod A_MOD one bit per cycle (MSB first),
// asks an external decoder for the error location matching the remainder,
// and applies a +/- 2^k correction when the location is usable.
// Optional build macro AN_SEC_STATS_EN enables the corrected/uncorrectable
// statistics counters; without it the counter ports read as 0.
module an_sec_correct_ctrl #(
  parameter int CW_W  = 52,
  parameter int A_MOD = 131,
  parameter int R_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic [R_W-1:0]    loc_r,
  input  logic signed [6:0] loc_l,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_cw,
  output logic [1:0]        out_status,
  input  logic              stat_clr,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       uncorr_cnt
);

  localparam int CNT_W = (CW_W > 1) ? $clog2(CW_W) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOD     = 3'd1,
    LOOKUP  = 3'd2,
    CORRECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [CW_W-1:0]   word;
  logic [R_W-1:0]    r;
  logic [CNT_W-1:0]  cnt;
  logic signed [6:0] l_reg;

  logic [R_W:0]      t;
  logic [R_W-1:0]    r_step;
  logic [7:0]        l_mag;
  logic              l_in_range;
  logic [CW_W:0]     pow, sum, diff;
  logic [CW_W-1:0]   fix_cw;
  logic [1:0]        fix_status;

  assign in_ready = (state == IDLE);
  assign loc_r    = (state == LOOKUP) ? r : {R_W{1'b0}};

  // One serial reduction step: t = 2r + bit, subtract A_MOD once if needed.
  assign t      = {r, word[cnt]};
  assign r_step = (t >= (R_W+1)'(A_MOD)) ? R_W'(t - (R_W+1)'(A_MOD)) : t[R_W-1:0];

  // Location magnitude (l = -64 gives 64) and the 2^(|l|-1) correction term.
  assign l_mag      = l_reg[6] ? (8'd0 - {l_reg[6], l_reg}) : {1'b0, l_reg};
  assign l_in_range = (l_mag != 8'd0) && (32'(l_mag) <= 32'(CW_W));
  assign pow        = (CW_W+1)'(1) << (l_mag - 8'd1);
  assign sum        = {1'b0, word} + pow;
  assign diff       = {1'b0, word} - pow;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = MOD;    else state_next = IDLE;
      MOD:     if (cnt == '0) state_next = LOOKUP; else state_next = MOD;
      LOOKUP:  state_next = CORRECT;
      CORRECT: state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;   else state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Correction decision: a borrow or carry means the location cannot be right.
  always_comb begin
    fix_cw     = word;
    fix_status = 2'b10;
    if (r == '0) begin
      fix_status = 2'b00;
    end else if (!l_in_range) begin
      fix_status = 2'b10;
    end else if (!l_reg[6]) begin
      if (diff[CW_W]) begin
        fix_status = 2'b10;
      end else begin
        fix_cw     = diff[CW_W-1:0];
        fix_status = 2'b01;
      end
    end else begin
      if (sum[CW_W]) begin
        fix_status = 2'b10;
      end else begin
        fix_cw     = sum[CW_W-1:0];
        fix_status = 2'b01;
      end
    end
  end

  // Datapath: capture, serial reduction, location latch and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      r          <= '0;
      cnt        <= '0;
      l_reg      <= 7'sd0;
      out_cw     <= '0;
      out_status <= 2'b00;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word <= in_cw;
            r    <= '0;
            cnt  <= CNT_W'(CW_W - 1);
          end
        end
        MOD: begin
          r   <= r_step;
          cnt <= cnt - CNT_W'(1);
        end
        LOOKUP:  l_reg <= loc_l;
        CORRECT: begin
          out_cw     <= fix_cw;
          out_status <= fix_status;
          out_valid  <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef AN_SEC_STATS_EN
  logic [15:0] corr_q, uncorr_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;

  // Saturating statistics, counted as the result enters DONE; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_q   <= 16'd0;
      uncorr_q <= 16'd0;
    end else if (stat_clr) begin
      corr_q   <= 16'd0;
      uncorr_q <= 16'd0;
    end else if (state == CORRECT) begin
      if (fix_status == 2'b01 && corr_q != 16'hFFFF) corr_q <= corr_q + 16'd1;
      if (fix_status == 2'b10 && uncorr_q != 16'hFFFF) uncorr_q <= uncorr_q + 16'd1;
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign corr_cnt        = 16'd0;
  assign uncorr_cnt      = 16'd0;
`endif

endmodule

// File: tb/tb_an_sec_correct_ctrl.sv
// Directed, table-driven bench for an_sec_correct_ctrl (default parameters).
// The external location decoder is modelled as: return the vector's location
// whenever loc_r is non-zero, else 0.
module tb_an_sec_correct_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [51:0]       in_cw;
  logic [7:0]        loc_r;
  logic signed [6:0] loc_l;
  logic              out_valid;
  logic              out_ready;
  logic [51:0]       out_cw;
  logic [1:0]        out_status;
  logic              stat_clr;
  logic [15:0]       corr_cnt;
  logic [15:0]       uncorr_cnt;

  logic signed [6:0] cur_l;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign loc_l = (loc_r != 8'd0) ? cur_l : 7'sd0;

  an_sec_correct_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .loc_r(loc_r), .loc_l(loc_l),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cw(out_cw), .out_status(out_status),
    .stat_clr(stat_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  typedef struct {
    logic [51:0]       cw;
    logic signed [6:0] l;
    logic [51:0]       ecw;
    logic [1:0]        est;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Run one codeword through; hold out_ready low for 'hold' cycles in DONE.
  task automatic run_vec(input vec_t v, input int hold);
    int n;
    int nz;
    logic [7:0] seen;
    logic [7:0] exp_r;
    exp_r = 8'(v.cw % 52'd131);
    cur_l = v.l;
    nz    = 0;
    seen  = 8'd0;
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_cw    = v.cw;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_cw    = 52'd0;
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    n = 0;
    while (!out_valid && n < 200) begin
      if (loc_r != 8'd0) begin
        nz++;
        seen = loc_r;
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd54);
    chk("loc_r_pulses", 64'(nz), (exp_r != 8'd0) ? 64'd1 : 64'd0);
    chk("loc_r_value", {56'd0, seen}, {56'd0, exp_r});
    chk("out_cw", {12'd0, out_cw}, {12'd0, v.ecw});
    chk("out_status", {62'd0, out_status}, {62'd0, v.est});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_cw", {12'd0, out_cw}, {12'd0, v.ecw});
      chk("hold_status", {62'd0, out_status}, {62'd0, v.est});
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int cnt_v;
    vecs[0]  = '{52'd655, 7'sd0, 52'd655, 2'b00};
    vecs[1]  = '{52'd659, 7'sd3, 52'd655, 2'b01};
    vecs[2]  = '{52'd654, -7'sd1, 52'd655, 2'b01};
    // Location +65 cannot be encoded in 7 signed bits; -63 is likewise out of range.
    vecs[3]  = '{52'd720, -7'sd63, 52'd720, 2'b10};
    vecs[4]  = '{52'd1, 7'sd0, 52'd1, 2'b10};
    vecs[5]  = '{52'd1, 7'sd2, 52'd1, 2'b10};
    vecs[6]  = '{52'h8_0000_0000_0000, 7'sd52, 52'd0, 2'b01};
    vecs[7]  = '{52'd1, -7'sd52, 52'h8_0000_0000_0001, 2'b01};
    vecs[8]  = '{52'd1, -7'sd53, 52'd1, 2'b10};
    vecs[9]  = '{52'hC_0000_0000_0000, -7'sd52, 52'hC_0000_0000_0000, 2'b10};
    vecs[10] = '{52'd1, 7'sd53, 52'd1, 2'b10};
    vecs[11] = '{52'd1, 7'sd1, 52'd0, 2'b01};

    rst = 1'b1; in_valid = 1'b0; in_cw = 52'd0; out_ready = 1'b0;
    stat_clr = 1'b0; cur_l = 7'sd0;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_cw", {12'd0, out_cw}, 64'd0);
    chk("rst_status", {62'd0, out_status}, 64'd0);
    chk("rst_loc_r", {56'd0, loc_r}, 64'd0);
    chk("rst_corr", {48'd0, corr_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], (i == 0) ? 10 : 1);

`ifdef AN_SEC_STATS_EN
    chk("corr_cnt", {48'd0, corr_cnt}, 64'd5);
    chk("uncorr_cnt", {48'd0, uncorr_cnt}, 64'd6);
`else
    chk("corr_cnt", {48'd0, corr_cnt}, 64'd0);
    chk("uncorr_cnt", {48'd0, uncorr_cnt}, 64'd0);
`endif
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("clr_corr", {48'd0, corr_cnt}, 64'd0);
    chk("clr_uncorr", {48'd0, uncorr_cnt}, 64'd0);

    // Reset in the middle of the reduction phase.
    cur_l = 7'sd3;
    @(negedge clk);
    in_cw = 52'd659; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_cw", {12'd0, out_cw}, 64'd0);
    chk("midrst_status", {62'd0, out_status}, 64'd0);
    chk("midrst_loc_r", {56'd0, loc_r}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_v = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) cnt_v++;
    end
    chk("midrst_no_output", 64'(cnt_v), 64'd0);
    run_vec(vecs[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
